// File: rtl/lake_config_loader.sv
// Word-serial config responder for lakespec: shadow words written over the bus,
// committed atomically into the active 550-bit vector on a rising flush edge.
module lake_config_loader #(
  parameter int CONFIG_WIDTH = 550,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [ADDR_WIDTH-1:0]   config_config_addr,
  input  logic [DATA_WIDTH-1:0]   config_config_data,
  input  logic                    config_write,
  input  logic                    config_read,
  output logic [DATA_WIDTH-1:0]   config_read_data,
  output logic                    config_read_valid,
  output logic [CONFIG_WIDTH-1:0] config_memory_size_550,
  output logic                    config_dirty,
  output logic                    config_complete,
  output logic                    config_addr_error
);

  localparam int NUM_WORDS = (CONFIG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam int LAST_BITS = CONFIG_WIDTH - (NUM_WORDS - 1) * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] LAST_MASK =
    {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - LAST_BITS);

  logic [DATA_WIDTH-1:0]   shadow [NUM_WORDS];
  logic [CONFIG_WIDTH-1:0] shadow_flat;
  logic [CONFIG_WIDTH-1:0] active;
  logic [NUM_WORDS-1:0]    written;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   word_mask;
  logic [IDX_W-1:0]        idx;
  logic                    flush_q;
  logic                    dirty;
  logic                    addr_err;
  logic                    rd_valid;
  logic                    in_range;
  logic                    wr_ok;
  logic                    commit;

  // Full-width compare so high address bits never alias onto real words.
  assign in_range  = config_config_addr < ADDR_WIDTH'(NUM_WORDS);
  assign idx       = config_config_addr[IDX_W-1:0];
  assign wr_ok     = config_write && in_range;
  assign commit    = flush && !flush_q;
  assign word_mask = (idx == IDX_W'(NUM_WORDS - 1)) ? LAST_MASK : '1;

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < NUM_WORDS - 1; k++) begin
      shadow_flat[k*DATA_WIDTH +: DATA_WIDTH] = shadow[k];
    end
    shadow_flat[CONFIG_WIDTH-1 -: LAST_BITS] =
      shadow[NUM_WORDS-1][LAST_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        shadow[k] <= '0;
      end
      written <= '0;
    end else if (wr_ok) begin
      shadow[idx]  <= config_config_data & word_mask;
      written[idx] <= 1'b1;
    end
  end

  // Commit samples the registered shadow, so a same-cycle write misses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= '0;
      flush_q <= 1'b0;
      dirty   <= 1'b0;
    end else begin
      flush_q <= flush;
      if (commit) begin
        active <= shadow_flat;
      end
      if (wr_ok) begin
        dirty <= 1'b1;
      end else if (commit) begin
        dirty <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= config_read;
      if (config_read) begin
        rd_data <= in_range ? shadow[idx] : '0;
      end
      if ((config_read || config_write) && !in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

  assign config_read_data       = rd_data;
  assign config_read_valid      = rd_valid;
  assign config_memory_size_550 = active;
  assign config_dirty           = dirty;
  assign config_complete        = &written;
  assign config_addr_error      = addr_err;

endmodule
